tick_gen_ctrl: RTL

TICK_GEN_CTRL -- requirements
Module: tick_gen_ctrl

---
 rtl/tick_gen_ctrl_if.sv | 13 +
 rtl/tick_gen_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/tick_gen_ctrl_if.sv
// Configuration handshake between a host and tick_gen_ctrl: half-period offer,
// ready back-pressure and a one-cycle reject pulse.
interface tick_gen_ctrl_if #(
  parameter int CNT_W = 27
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_half, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_gen_ctrl.sv
// Programmable 50%-duty slow clock / tick generator with run and single-step
// modes; half-period updates land only on period boundaries.
module tick_gen_ctrl #(
  parameter int CNT_W    = 27,
  parameter int DEF_HALF = 100_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           step,
  tick_gen_ctrl_if.slave cfg,
  output logic           slow_clk,
  output logic           tick,
  output logic           busy
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] active_half, active_nx;
  logic [CNT_W-1:0] pend_half, pend_half_nx;
  logic             pend_vld, pend_vld_nx;
  logic             slow_nx, tick_nx, err_nx;
  logic             xfer, cfg_ok;
  logic [CNT_W-1:0] start_half, relaunch_half;

  assign cfg.cfg_ready = ~pend_vld;
  assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg_ok        = xfer & (cfg.cfg_half != '0);
  assign busy          = (state != IDLE);

  // Half used by a period launched from IDLE: a same-cycle accept wins, and a
  // value left pending by the last LOW exit is applied before launching.
  assign start_half    = cfg_ok   ? cfg.cfg_half :
                         pend_vld ? pend_half    : active_half;
  assign relaunch_half = pend_vld ? pend_half    : active_half;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    active_nx    = active_half;
    pend_half_nx = pend_half;
    pend_vld_nx  = pend_vld;
    tick_nx      = 1'b0;
    err_nx       = xfer & (cfg.cfg_half == '0);
    case (state)
      IDLE: begin
        active_nx   = start_half;
        pend_vld_nx = 1'b0;
        if (run || step) begin
          state_nx = HIGH;
          cnt_nx   = start_half - ONE;
          tick_nx  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nx = LOW;
          cnt_nx   = active_half - ONE;
        end else begin
          cnt_nx = cnt - ONE;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          active_nx   = relaunch_half;
          pend_vld_nx = 1'b0;
          if (run) begin
            state_nx = HIGH;
            cnt_nx   = relaunch_half - ONE;
            tick_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt - ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // While a period runs, accepted values wait so no period mixes halves.
    if (busy && cfg_ok) begin
      pend_vld_nx  = 1'b1;
      pend_half_nx = cfg.cfg_half;
    end
    slow_nx = (state_nx == HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      active_half <= DEF;
      pend_half   <= '0;
      pend_vld    <= 1'b0;
      slow_clk    <= 1'b0;
      tick        <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      active_half <= active_nx;
      pend_half   <= pend_half_nx;
      pend_vld    <= pend_vld_nx;
      slow_clk    <= slow_nx;
      tick        <= tick_nx;
      cfg.cfg_err <= err_nx;
    end
  end

endmodule
